alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATAW, default 4, width of ALU operands; results are 2*DATAW.
REQ-002 Parameter ALU_LAT, default 2, clock edges from ALU inputs presented to result valid.
REQ-003 Parameter FIFO_DEPTH, default 4, response FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 i_flush  input  1  discard all outstanding commands and responses.
REQ-007 i_cmd_valid  input  1  command offered.
REQ-008 o_cmd_ready  output  1  command accepted when valid and ready both high.
REQ-009 i_cmd_dataa / i_cmd_datab  input  DATAW  operands.
REQ-010 i_cmd_op  input  2  00 RST, 01 SHL, 10 signed ADD, 11 signed SUB.
REQ-011 o_alu_dataa / o_alu_datab  output  DATAW  registered operands to ALU.
REQ-012 o_alu_op  output  2  registered op to ALU.
REQ-013 i_alu_result  input  2*DATAW  ALU output.
REQ-014 o_rsp_valid  output  1  response available.
REQ-015 i_rsp_ready  input  1  response consumed when valid and ready both high.
REQ-016 o_rsp_result  output  2*DATAW  ALU result for head response.
REQ-017 o_rsp_op  output  2  op of head response.
REQ-018 o_rsp_tag  output  4  sequence tag of head response.

Function
REQ-019 On accept at edge E, o_alu_* SHALL carry the command from E for exactly one cycle; otherwise o_alu_op=00, operands 0.
REQ-020 i_alu_result SHALL be captured into the FIFO at edge E+ALU_LAT, with op and tag carried by an ALU_LAT-deep valid/op/tag shift pipeline.
REQ-021 Minimum accept-to-o_rsp_valid latency SHALL be ALU_LAT+1 cycles (valid visible after edge E+ALU_LAT).
REQ-022 o_cmd_ready SHALL be high iff state RUN and (in-flight count + FIFO count) < FIFO_DEPTH; FIFO overflow is therefore impossible.
REQ-023 Tag SHALL start at 0, increment by one per accepted command, wrap 15->0.
REQ-024 Responses SHALL leave in acceptance order; o_rsp_* held stable while o_rsp_valid high and i_rsp_ready low.
REQ-025 Simultaneous push and pop SHALL leave FIFO count unchanged; pop on empty has no effect.
REQ-026 Back-to-back accepts every cycle SHALL be sustained while i_rsp_ready stays high.
REQ-027 States: RUN, FLUSH. RUN->FLUSH on i_flush; FLUSH lasts ALU_LAT cycles then returns to RUN; i_flush in FLUSH restarts the count.
REQ-028 Entering FLUSH SHALL empty the FIFO, clear the shift pipeline, deassert o_cmd_ready and o_rsp_valid; ALU results arriving during FLUSH are dropped; tag is not reset.
REQ-029 i_flush concurrent with i_cmd_valid SHALL not accept the command.

Reset
REQ-030 rst_n low at an edge SHALL set state RUN, tag 0, FIFO and pipeline empty, o_alu_* 0, o_rsp_valid 0, o_rsp_* 0; o_cmd_ready 0 while rst_n low.
REQ-031 Reset mid-operation SHALL discard all in-flight and queued responses; rst_n has priority over i_flush.

Structure
REQ-032 Shared package alu_pkg SHALL hold the op enum (RST, SHL, ADD, SUB) and a response struct (result, op, tag).
REQ-033 Response storage SHALL be a separate sub-module alu_rsp_fifo (synchronous FIFO, count output, flush input).

Verification
REQ-034 Accept A=0011 B=0010 op SHL, i_rsp_ready=1 -> o_rsp_result=00001100, tag 0, o_rsp_valid 3 cycles after accept.
REQ-035 ADD A=0111 B=0001 then SUB A=1000 B=0001 back-to-back -> results 00001000 and 11110111, tags 0,1, in order.
REQ-036 i_rsp_ready=0, 10 commands offered -> exactly 4 accepted, o_cmd_ready low; release ready -> four responses, then acceptance resumes.
REQ-037 17 accepted commands -> 17th response tag = 0 (wrap).
REQ-038 Two commands in flight, assert i_flush -> no response emerges, o_cmd_ready low 2 cycles, next command returns next tag.
REQ-039 rst_n low for one cycle with 3 responses queued -> o_rsp_valid 0 next cycle, next accepted command tag 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU issue controller: ALU opcode encoding, controller
// state, sequence tag and the response record queued for the consumer.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_RST = 2'b00,
        OP_SHL = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int unsigned TAG_W     = 4;
    localparam int unsigned DEF_DATAW = 4;

    typedef logic [TAG_W-1:0] tag_t;

    // Response record for the default operand width. The controller builds the
    // same layout with the result sized from its own DATAW parameter.
    typedef struct packed {
        logic [2*DEF_DATAW-1:0] result;
        op_e                    op;
        tag_t                   tag;
    } rsp_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles the command handshake, the ALU-facing bus and the response handshake
// of alu_issue_ctrl.
//   slave  : controller view (i_* inputs, o_* outputs)
//   master : environment view (drives i_*, observes o_*)
// Signals:
//   i_cmd_valid/o_cmd_ready, i_cmd_dataa/datab[DATAW], i_cmd_op[2]  command
//   o_alu_dataa/datab[DATAW], o_alu_op[2], i_alu_result[2*DATAW]    ALU bus
//   o_rsp_valid/i_rsp_ready, o_rsp_result[2*DATAW], o_rsp_op[2],
//   o_rsp_tag[4]                                                     response
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int unsigned DATAW = 4
);
    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic [DATAW-1:0]     i_cmd_dataa;
    logic [DATAW-1:0]     i_cmd_datab;
    logic [1:0]           i_cmd_op;

    logic [DATAW-1:0]     o_alu_dataa;
    logic [DATAW-1:0]     o_alu_datab;
    logic [1:0]           o_alu_op;
    logic [2*DATAW-1:0]   i_alu_result;

    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [2*DATAW-1:0]   o_rsp_result;
    logic [1:0]           o_rsp_op;
    logic [3:0]           o_rsp_tag;

    modport slave (
        input  i_cmd_valid, i_cmd_dataa, i_cmd_datab, i_cmd_op,
        input  i_alu_result, i_rsp_ready,
        output o_cmd_ready, o_alu_dataa, o_alu_datab, o_alu_op,
        output o_rsp_valid, o_rsp_result, o_rsp_op, o_rsp_tag
    );

    modport master (
        output i_cmd_valid, i_cmd_dataa, i_cmd_datab, i_cmd_op,
        output i_alu_result, i_rsp_ready,
        input  o_cmd_ready, o_alu_dataa, o_alu_datab, o_alu_op,
        input  o_rsp_valid, o_rsp_result, o_rsp_op, o_rsp_tag
    );
endinterface

// File: rtl/alu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// alu_rsp_fifo
// Synchronous show-ahead FIFO holding ALU responses in acceptance order.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_flush      empties the FIFO (wins over push/pop at the same edge)
//   i_push       write i_data (ignored when full and not popping)
//   i_pop        consume head (ignored when empty)
//   o_valid      FIFO not empty
//   o_data       head entry, all zero while empty
//   o_count      current number of entries
// -----------------------------------------------------------------------------
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter type         T     = rsp_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output T                         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_do_push;
    logic        w_do_pop;

    always_comb begin
        w_count   = r_wr_ptr - r_rd_ptr;
        w_empty   = (w_count == '0);
        w_full    = (w_count == (AW+1)'(DEPTH));
        w_do_pop  = i_pop && !w_empty;
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_comb begin
        o_valid = !w_empty;
        o_count = w_count;
        if (w_empty) o_data = '0;
        else         o_data = r_mem[r_rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues commands to a fixed-latency ALU, tags them with a 4-bit sequence
// number, tracks them through an ALU_LAT-deep pipeline and queues the results
// in a response FIFO. Admission is credit-limited so the FIFO cannot overflow.
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset (priority over i_flush)
//   i_flush    drop all outstanding commands and responses
//   bus        alu_issue_ctrl_if.slave: command, ALU and response buses
// Parameters: DATAW operand width, ALU_LAT ALU latency in edges (>=1),
//   FIFO_DEPTH response FIFO entries (power of two, >=2).
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATAW      = 4,
    parameter int unsigned ALU_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    alu_issue_ctrl_if.slave   bus
);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    // Same layout as alu_pkg::rsp_t with the result sized by DATAW.
    typedef struct packed {
        logic [2*DATAW-1:0] result;
        op_e                op;
        tag_t               tag;
    } rsp_w_t;

    state_e             r_state;
    logic [FCW-1:0]     r_fcnt;
    tag_t               r_tag;

    logic [DATAW-1:0]   r_alu_a;
    logic [DATAW-1:0]   r_alu_b;
    op_e                r_alu_op;

    logic               r_pv   [ALU_LAT];
    op_e                r_pop  [ALU_LAT];
    tag_t               r_ptag [ALU_LAT];

    logic               w_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_rsp_valid;
    logic [CW-1:0]      w_fifo_count;
    int unsigned        w_occ;
    rsp_w_t             w_push_data;
    rsp_w_t             w_head;

    // Occupancy = commands still inside the ALU plus queued responses. Every
    // in-flight command already owns a FIFO slot, so admission against this
    // sum guarantees a free entry when its result lands.
    always_comb begin
        w_occ = 32'(w_fifo_count);
        for (int unsigned i = 0; i < ALU_LAT; i++) begin
            w_occ = w_occ + 32'(r_pv[i]);
        end
    end

    // i_flush blocks acceptance in its own cycle so a concurrent command is
    // never issued into a pipeline that is being cleared.
    always_comb begin
        w_ready  = rst_n && (r_state == ST_RUN) && !i_flush && (w_occ < FIFO_DEPTH);
        w_accept = bus.i_cmd_valid && w_ready;
        w_push   = r_pv[ALU_LAT-1];
        w_push_data.result = bus.i_alu_result;
        w_push_data.op     = r_pop[ALU_LAT-1];
        w_push_data.tag    = r_ptag[ALU_LAT-1];
    end

    // Controller state: FLUSH holds for ALU_LAT cycles, re-armed by i_flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else if (i_flush) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= FCW'(ALU_LAT - 1);
        end else begin
            case (r_state)
                ST_RUN: r_state <= ST_RUN;
                ST_FLUSH: begin
                    if (r_fcnt == '0) r_state <= ST_RUN;
                    else              r_fcnt  <= r_fcnt - 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // ALU drive registers and sequence tag. The tag survives a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= OP_RST;
        end else begin
            if (w_accept) r_tag <= r_tag + 1'b1;
            r_alu_a  <= w_accept ? bus.i_cmd_dataa : '0;
            r_alu_b  <= w_accept ? bus.i_cmd_datab : '0;
            r_alu_op <= w_accept ? op_e'(bus.i_cmd_op) : OP_RST;
        end
    end

    // Valid/op/tag shift pipeline aligned with the ALU latency.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            for (int unsigned i = 0; i < ALU_LAT; i++) begin
                r_pv[i]   <= 1'b0;
                r_pop[i]  <= OP_RST;
                r_ptag[i] <= '0;
            end
        end else begin
            r_pv[0]   <= w_accept;
            r_pop[0]  <= op_e'(bus.i_cmd_op);
            r_ptag[0] <= r_tag;
            for (int unsigned i = 1; i < ALU_LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pop[i]  <= r_pop[i-1];
                r_ptag[i] <= r_ptag[i-1];
            end
        end
    end

    alu_rsp_fifo #(
        .T     (rsp_w_t),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (bus.i_rsp_ready),
        .o_valid (w_rsp_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign bus.o_cmd_ready  = w_ready;
    assign bus.o_alu_dataa  = r_alu_a;
    assign bus.o_alu_datab  = r_alu_b;
    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_rsp_valid  = w_rsp_valid;
    assign bus.o_rsp_result = w_head.result;
    assign bus.o_rsp_op     = w_head.op;
    assign bus.o_rsp_tag    = w_head.tag;

endmodule
